// File: rtl/mac8_seq_core.sv
// mac8_seq_core: sequential 8x8 unsigned multiply-accumulate controller.
// Each product is built by shift-and-add over 8 cycles, then added into the
// running accumulator in one more cycle. Every addition goes through a single
// shared ACC_W-bit ripple adder made of reversible_full_adder cells.
// Optional feature macro: MAC8_SATURATE_EN. When it is defined, an accumulate
// that carries out of the top bit clamps acc_out to all ones. When it is not
// defined, the accumulator wraps modulo 2^ACC_W.
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// 1. in_ready and out_valid come only from registered state. The source holds
// its payload stable until the transfer.

// Reversible full adder cell. With ctrl = 0 it is a plain full adder.
// With ctrl = 1 it inverts the b input, which supports subtract-style use.
module reversible_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic ctrl,
    output logic sum,
    output logic cout
);
    logic b_eff;

    // Full-adder equations on the conditionally inverted b input
    always_comb begin
        b_eff = b ^ ctrl;
        sum   = a ^ b_eff ^ cin;
        cout  = (a & b_eff) | (cin & (a ^ b_eff));
    end
endmodule

module mac8_seq_core #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             out_ovf,
    output logic [1:0]       dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_ACC  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       mcand;
    logic [7:0]       mplier;
    logic [15:0]      product;
    logic [2:0]       step;
    logic             clr_q;

    logic [15:0]      shifted;
    logic [ACC_W-1:0] op_a;
    logic [ACC_W-1:0] op_b;
    logic [ACC_W-1:0] sum;
    logic [ACC_W:0]   carry;
    logic             carry_out;

    assign dbg_state = state;

    // Multiplicand shifted into position for the current multiply step
    always_comb begin
        shifted = 16'({8'h00, mcand}) << step;
    end

    // Adder operand mux: partial-product add in MUL, accumulate in ACC
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            S_MUL: begin
                op_a = ACC_W'(product);
                op_b = ACC_W'(shifted);
            end
            S_ACC: begin
                op_a = clr_q ? '0 : acc_out;
                op_b = ACC_W'(product);
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase
    end

    // Shared ripple-carry adder; the carry out of the top cell is the overflow carry
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < ACC_W; i++) begin : g_rca
        reversible_full_adder u_fa (
            .a    (op_a[i]),
            .b    (op_b[i]),
            .cin  (carry[i]),
            .ctrl (1'b0),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end
    assign carry_out = carry[ACC_W];

    // Control FSM with registered handshake outputs and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mcand     <= '0;
            mplier    <= '0;
            product   <= '0;
            step      <= '0;
            clr_q     <= 1'b0;
            acc_out   <= '0;
            out_ovf   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        mcand    <= in_a;
                        mplier   <= in_b;
                        clr_q    <= in_clr;
                        product  <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    // A product never exceeds 16 bits, so only the low bits are kept
                    if (mplier[step]) begin
                        product <= sum[15:0];
                    end
                    if (step == 3'd7) begin
                        state <= S_ACC;
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                S_ACC: begin
`ifdef MAC8_SATURATE_EN
                    if (carry_out) begin
                        acc_out <= '1;
                        out_ovf <= 1'b1;
                    end else begin
                        acc_out <= sum;
                        out_ovf <= clr_q ? 1'b0 : out_ovf;
                    end
`else
                    acc_out <= sum;
                    out_ovf <= (clr_q ? 1'b0 : out_ovf) | carry_out;
`endif
                    out_valid <= 1'b1;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac8_seq_core.sv
// Testbench for mac8_seq_core at ACC_W = 16. The reference model works on
// plain integers: base + a*b, then detects the carry past 2^16. It handles
// both the wrap and saturate builds (MAC8_SATURATE_EN).
module tb_mac8_seq_core;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_a;
    logic [7:0]   in_b;
    logic         in_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] acc_out;
    logic         out_ovf;
    logic [1:0]   dbg_state;

    int total;
    int bad;

    // Reference model state and scoreboard of {ovf, acc}
    logic [W-1:0] m_acc;
    logic         m_ovf;
    logic [W:0]   exp_q[$];
    logic [W-1:0] last_acc;

    mac8_seq_core #(.ACC_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_clr    (in_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .out_ovf   (out_ovf),
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one accumulate operation computed with integer arithmetic
    task automatic model_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
        int unsigned base;
        int unsigned s;
        logic        cy;
        base = clr ? 0 : int'(m_acc);
        s    = base + int'(a) * int'(b);
        cy   = (s >= (32'd1 << W));
`ifdef MAC8_SATURATE_EN
        if (cy) begin
            m_acc = '1;
            m_ovf = 1'b1;
        end else begin
            m_acc = s[W-1:0];
            m_ovf = clr ? 1'b0 : m_ovf;
        end
`else
        m_acc = s[W-1:0];
        m_ovf = (clr ? 1'b0 : m_ovf) | cy;
`endif
        exp_q.push_back({m_ovf, m_acc});
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_ovf = 1'b0;
        exp_q.delete();
    endtask

    // Driver: present operands just after a falling edge; the next rising edge is the handshake
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic clr);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_clr   = clr;
        check("ready_before_op", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom_range(0, 255));
        in_b     = 8'($urandom_range(0, 255));
        in_clr   = 1'($urandom_range(0, 1));
    endtask

    // Wait the fixed latency, check the result, hold backpressure, then release
    task automatic finish_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                             input int hold);
        logic       early;
        logic [W:0] e;
        early = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) early = 1'b1;
        end
        check("valid_early", early, 0);
        @(negedge clk);
        model_op(a, b, clr);
        e = exp_q.pop_front();
        check("valid_at_k9", out_valid, 1);
        check("acc_out", acc_out, e[W-1:0]);
        check("out_ovf", out_ovf, e[W]);
        last_acc = acc_out;
        repeat (hold) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1);
            check("bp_acc_stable", acc_out, e[W-1:0]);
            check("bp_ready_low", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("ready_after_out", in_ready, 1);
        check("valid_after_out", out_valid, 0);
    endtask

    initial begin
        logic seen;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        in_clr    = 1'b0;
        out_ready = 1'b0;
        model_reset();

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc", acc_out, 0);
        check("rst_ovf", out_ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single product
        start_op(8'hFF, 8'hFF, 1'b1);
        finish_op(8'hFF, 8'hFF, 1'b1, 0);
        check("ff_times_ff", last_acc, 16'hFE01);

        // Accumulation
        start_op(8'd3, 8'd4, 1'b1);
        finish_op(8'd3, 8'd4, 1'b1, 0);
        check("acc_first", last_acc, 16'h000C);
        start_op(8'd5, 8'd6, 1'b0);
        finish_op(8'd5, 8'd6, 1'b0, 1);
        check("acc_second", last_acc, 16'h002A);
        start_op(8'd2, 8'd2, 1'b1);
        finish_op(8'd2, 8'd2, 1'b1, 0);
        check("acc_clear", last_acc, 16'h0004);

        // Overflow
        start_op(8'hFF, 8'hFF, 1'b1);
        finish_op(8'hFF, 8'hFF, 1'b1, 0);
        start_op(8'h20, 8'h10, 1'b0);
        finish_op(8'h20, 8'h10, 1'b0, 0);
`ifdef MAC8_SATURATE_EN
        check("ovf_result", last_acc, 16'hFFFF);
`else
        check("ovf_result", last_acc, 16'h0001);
`endif
        check("ovf_flag", out_ovf, 1);
        start_op(8'd1, 8'd1, 1'b1);
        finish_op(8'd1, 8'd1, 1'b1, 0);
        check("ovf_cleared", out_ovf, 0);

        // Backpressure with pending operands held by upstream
        start_op(8'h11, 8'h22, 1'b0);
        in_valid = 1'b1;
        in_a     = 8'h33;
        in_b     = 8'h44;
        in_clr   = 1'b0;
        finish_op(8'h11, 8'h22, 1'b0, 5);
        @(negedge clk);
        in_valid = 1'b0;
        finish_op(8'h33, 8'h44, 1'b0, 0);

        // Reset while the result is waiting in DONE
        start_op(8'h12, 8'h34, 1'b1);
        repeat (9) @(negedge clk);
        check("done_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_ready", in_ready, 1);
        check("async_rst_acc", acc_out, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset mid-MUL: the aborted operation must never produce a result
        start_op(8'd7, 8'd9, 1'b1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check("midmul_ready", in_ready, 1);
        check("midmul_acc", acc_out, 0);
        check("midmul_ovf", out_ovf, 0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("midmul_no_valid", seen, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = ($urandom_range(0, 3) == 0);
            start_op(ra, rb, rc);
            finish_op(ra, rb, rc, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
